// File: rtl/gin_multicast_bus_if.sv
// GIN multicast bus interface: GLB-side stream, scan chains, PE side, status.
// master = GLB/PE-array environment, slave = the bus itself.
interface gin_multicast_bus_if #(
   parameter int NUM_ROW   = 12,
   parameter int NUM_COL   = 14,
   parameter int XID_BITS  = 5,
   parameter int YID_BITS  = 4,
   parameter int DATA_BITS = 32,
   parameter int CNT_BITS  = 16
);
   localparam int N = NUM_ROW * NUM_COL;

   logic                 set_xid;
   logic [XID_BITS-1:0]  xid_scan_in;
   logic                 set_yid;
   logic [YID_BITS-1:0]  yid_scan_in;
   logic [XID_BITS-1:0]  tag_x;
   logic [YID_BITS-1:0]  tag_y;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_BITS-1:0] in_data;
   logic [N-1:0]         pe_valid;
   logic [N-1:0]         pe_ready;
   logic [DATA_BITS-1:0] pe_data;
   logic                 busy;
   logic [CNT_BITS-1:0]  xfer_cnt;
   logic [CNT_BITS-1:0]  drop_cnt;
   logic                 drop_err;

   modport master (
      output set_xid, xid_scan_in, set_yid, yid_scan_in,
      output tag_x, tag_y, in_valid, in_data, pe_ready,
      input  in_ready, pe_valid, pe_data,
      input  busy, xfer_cnt, drop_cnt, drop_err
   );

   modport slave (
      input  set_xid, xid_scan_in, set_yid, yid_scan_in,
      input  tag_x, tag_y, in_valid, in_data, pe_ready,
      output in_ready, pe_valid, pe_data,
      output busy, xfer_cnt, drop_cnt, drop_err
   );
endinterface

// File: rtl/gin_multicast_bus.sv
// Global input network: registered multicast of one GLB stream to all PEs
// whose scanned (X,Y) ID matches the tag. Ports: clk, rst, bus (slave).
module gin_multicast_bus #(
   parameter int NUM_ROW   = 12,
   parameter int NUM_COL   = 14,
   parameter int XID_BITS  = 5,
   parameter int YID_BITS  = 4,
   parameter int DATA_BITS = 32,
   parameter int CNT_BITS  = 16
) (
   input logic                clk,
   input logic                rst,
   gin_multicast_bus_if.slave bus
);
   localparam int N = NUM_ROW * NUM_COL;
   localparam logic [XID_BITS-1:0] X_ALL = '1;
   localparam logic [YID_BITS-1:0] Y_ALL = '1;
   localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t               state, state_nxt;
   logic [XID_BITS-1:0]  xid [N];
   logic [YID_BITS-1:0]  yid [NUM_ROW];
   logic [N-1:0]         mask, match, remain;
   logic [DATA_BITS-1:0] data_q;
   logic [CNT_BITS-1:0]  xfer_q, drop_q;
   logic                 err_q;
   logic                 scanning, retire, accept, hit, drop;
   logic                 x_wild, y_wild;

   assign x_wild = (bus.tag_x == X_ALL);
   assign y_wild = (bus.tag_y == Y_ALL);

   for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
      for (genvar c = 0; c < NUM_COL; c++) begin : g_col
         localparam int I = r * NUM_COL + c;
         assign match[I] = (x_wild || bus.tag_x == xid[I]) &&
                           (y_wild || bus.tag_y == yid[r]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Retire is combinational from pe_ready so the next word can be taken
   // in the same cycle the last outstanding PE handshakes.
   always_comb begin
      scanning     = bus.set_xid | bus.set_yid;
      remain       = mask & ~bus.pe_ready;
      state_nxt    = state;
      retire       = 1'b0;
      bus.in_ready = 1'b0;
      bus.pe_valid = '0;
      bus.busy     = 1'b0;
      unique case (state)
         EMPTY: begin
            bus.in_ready = ~scanning;
         end
         HOLD: begin
            bus.busy     = 1'b1;
            bus.pe_valid = mask;
            retire       = (remain == '0);
            bus.in_ready = retire & ~scanning;
            state_nxt    = retire ? EMPTY : HOLD;
         end
      endcase
      accept = bus.in_valid & bus.in_ready;
      hit    = accept & (|match);
      drop   = accept & ~(|match);
      if (hit) state_nxt = HOLD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask   <= '0;
         data_q <= '0;
         xfer_q <= '0;
         drop_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < N; i++) xid[i] <= '0;
         for (int i = 0; i < NUM_ROW; i++) yid[i] <= '0;
      end else begin
         // The mask is latched at accept, so scanning never disturbs it.
         if (hit) begin
            mask   <= match;
            data_q <= bus.in_data;
         end else begin
            mask <= remain;
         end
         if (retire && xfer_q != '1) xfer_q <= xfer_q + CNT_ONE;
         if (drop) begin
            err_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + CNT_ONE;
         end
         if (bus.set_xid) begin
            for (int i = 0; i < N - 1; i++) xid[i] <= xid[i+1];
            xid[N-1] <= bus.xid_scan_in;
         end
         if (bus.set_yid) begin
            for (int i = 0; i < NUM_ROW - 1; i++) yid[i] <= yid[i+1];
            yid[NUM_ROW-1] <= bus.yid_scan_in;
         end
      end
   end

   assign bus.pe_data  = data_q;
   assign bus.xfer_cnt = xfer_q;
   assign bus.drop_cnt = drop_q;
   assign bus.drop_err = err_q;
endmodule

// File: tb/tb_gin_multicast_bus.sv
// Self-checking bench for gin_multicast_bus on a 2x3 array, 3-bit IDs.
// Directed scenarios plus random traffic against a destination-set model.
module tb_gin_multicast_bus;
   localparam int NR = 2;
   localparam int NC = 3;
   localparam int XB = 3;
   localparam int YB = 3;
   localparam int DB = 8;
   localparam int CB = 8;
   localparam int N  = NR * NC;

   localparam logic [N-1:0] RDY_TAB [5] =
      '{6'h01, 6'h01, 6'h05, 6'h05, 6'h07};
   localparam logic [N-1:0] VAL_TAB [5] =
      '{6'h07, 6'h06, 6'h06, 6'h02, 6'h02};
   localparam logic IRDY_TAB [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gin_multicast_bus_if #(
      .NUM_ROW(NR), .NUM_COL(NC), .XID_BITS(XB),
      .YID_BITS(YB), .DATA_BITS(DB), .CNT_BITS(CB)
   ) bus ();

   gin_multicast_bus #(
      .NUM_ROW(NR), .NUM_COL(NC), .XID_BITS(XB),
      .YID_BITS(YB), .DATA_BITS(DB), .CNT_BITS(CB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: IDs, set of PEs still owed the held word, counters.
   logic [XB-1:0] m_xid [N];
   logic [YB-1:0] m_yid [NR];
   bit            m_busy;
   logic [N-1:0]  m_pend;
   logic [DB-1:0] m_data;
   int            m_xfer, m_drop;
   bit            m_err;

   function automatic logic [N-1:0] m_match(logic [XB-1:0] tx,
                                            logic [YB-1:0] ty);
      logic [N-1:0] m;
      m = '0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            m[r*NC+c] = (tx == 3'd7 || tx == m_xid[r*NC+c]) &&
                        (ty == 3'd7 || ty == m_yid[r]);
      return m;
   endfunction

   function automatic bit m_rdy();
      if (bus.set_xid || bus.set_yid) return 1'b0;
      if (!m_busy) return 1'b1;
      return (m_pend & ~bus.pe_ready) == '0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_xid[i] = '0;
      for (int i = 0; i < NR; i++) m_yid[i] = '0;
      m_busy = 0; m_pend = '0; m_data = '0;
      m_xfer = 0; m_drop = 0; m_err = 0;
   endtask

   task automatic idle();
      bus.set_xid = 0; bus.xid_scan_in = '0;
      bus.set_yid = 0; bus.yid_scan_in = '0;
      bus.tag_x = '0; bus.tag_y = '0;
      bus.in_valid = 0; bus.in_data = '0;
      bus.pe_ready = '0;
   endtask

   // Advance one clock and apply the specified effects to the model.
   task automatic tick();
      bit acc;
      logic [N-1:0] mv, rem, pr;
      logic sx, sy;
      logic [XB-1:0] xi;
      logic [YB-1:0] yi;
      logic [DB-1:0] d;
      acc = bus.in_valid && m_rdy();
      mv  = m_match(bus.tag_x, bus.tag_y);
      pr  = bus.pe_ready;
      sx = bus.set_xid; sy = bus.set_yid;
      xi = bus.xid_scan_in; yi = bus.yid_scan_in;
      d  = bus.in_data;
      @(posedge clk);
      if (m_busy) begin
         rem = m_pend & ~pr;
         if (rem == '0) begin
            m_busy = 0; m_pend = '0;
            if (m_xfer < 255) m_xfer++;
         end else begin
            m_pend = rem;
         end
      end
      if (acc) begin
         if (mv == '0) begin
            if (m_drop < 255) m_drop++;
            m_err = 1;
         end else begin
            m_busy = 1; m_pend = mv; m_data = d;
         end
      end
      if (sx) begin
         for (int i = 0; i < N - 1; i++) m_xid[i] = m_xid[i+1];
         m_xid[N-1] = xi;
      end
      if (sy) begin
         for (int i = 0; i < NR - 1; i++) m_yid[i] = m_yid[i+1];
         m_yid[NR-1] = yi;
      end
   endtask

   task automatic scan_x(input logic [XB-1:0] v);
      @(negedge clk); idle();
      bus.set_xid = 1; bus.xid_scan_in = v;
      tick();
   endtask

   task automatic scan_y(input logic [YB-1:0] v);
      @(negedge clk); idle();
      bus.set_yid = 1; bus.yid_scan_in = v;
      tick();
   endtask

   task automatic test_reset();
      rst = 1; idle(); m_reset();
      repeat (2) @(negedge clk);
      checks += 5;
      if (bus.busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy got %b want 0", bus.busy); end
      if (bus.pe_valid !== 6'h00) begin errors++;
         $display("FAIL reset_pe_valid got %h want 00", bus.pe_valid); end
      if (bus.pe_data !== 8'h00) begin errors++;
         $display("FAIL reset_pe_data got %h want 00", bus.pe_data); end
      if (bus.xfer_cnt !== 8'd0 || bus.drop_cnt !== 8'd0) begin errors++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0",
                  bus.xfer_cnt, bus.drop_cnt); end
      if (bus.drop_err !== 1'b0) begin errors++;
         $display("FAIL reset_drop_err got %b want 0", bus.drop_err); end
      rst = 0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_unicast();
      for (int i = 0; i < N; i++) scan_x(XB'(i % 3));
      scan_y(3'd0); scan_y(3'd1);
      @(negedge clk); idle();
      bus.in_valid = 1; bus.tag_x = 3'd1; bus.tag_y = 3'd1;
      bus.in_data = 8'hA5;
      #1; checks++;
      if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL uni_accept got %b want 1", bus.in_ready); end
      tick();
      @(negedge clk); idle(); bus.pe_ready = 6'b010000;
      #1; checks += 3;
      if (bus.pe_valid !== 6'b010000) begin errors++;
         $display("FAIL uni_pe_valid got %b want 010000", bus.pe_valid); end
      if (bus.pe_data !== 8'hA5) begin errors++;
         $display("FAIL uni_pe_data got %h want a5", bus.pe_data); end
      if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL uni_retire_rdy got %b want 1", bus.in_ready); end
      tick();
      @(negedge clk); idle();
      #1; checks += 2;
      if (bus.pe_valid !== 6'h00 || bus.busy !== 1'b0) begin errors++;
         $display("FAIL uni_done got v=%b b=%b want 0/0",
                  bus.pe_valid, bus.busy); end
      if (bus.xfer_cnt !== 8'd1) begin errors++;
         $display("FAIL uni_xfer got %0d want 1", bus.xfer_cnt); end
   endtask

   task automatic test_staggered();
      int hs [N];
      for (int i = 0; i < N; i++) hs[i] = 0;
      @(negedge clk); idle();
      bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd0;
      bus.in_data = 8'h11;
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); idle(); bus.pe_ready = RDY_TAB[k];
         #1; checks += 2;
         if (bus.pe_valid !== VAL_TAB[k]) begin errors++;
            $display("FAIL stag_valid[%0d] got %b want %b",
                     k, bus.pe_valid, VAL_TAB[k]); end
         if (bus.in_ready !== IRDY_TAB[k]) begin errors++;
            $display("FAIL stag_in_ready[%0d] got %b want %b",
                     k, bus.in_ready, IRDY_TAB[k]); end
         for (int i = 0; i < N; i++)
            hs[i] += int'(bus.pe_valid[i] & bus.pe_ready[i]);
         tick();
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (hs[i] != (i < 3 ? 1 : 0)) begin errors++;
            $display("FAIL stag_handshakes[%0d] got %0d want %0d",
                     i, hs[i], (i < 3 ? 1 : 0)); end
      end
      @(negedge clk); idle();
      #1; checks += 2;
      if (bus.pe_valid !== 6'h00) begin errors++;
         $display("FAIL stag_end_valid got %b want 0", bus.pe_valid); end
      if (bus.xfer_cnt !== 8'd2) begin errors++;
         $display("FAIL stag_xfer got %0d want 2", bus.xfer_cnt); end
   endtask

   task automatic test_drop();
      @(negedge clk); idle();
      bus.in_valid = 1; bus.tag_x = 3'd5; bus.tag_y = 3'd0;
      bus.in_data = 8'hEE;
      #1; checks++;
      if (bus.in_ready !== 1'b1) begin errors++;
         $display("FAIL drop_rdy got %b want 1", bus.in_ready); end
      tick();
      @(negedge clk); idle();
      #1; checks += 4;
      if (bus.pe_valid !== 6'h00 || bus.busy !== 1'b0) begin errors++;
         $display("FAIL drop_idle got v=%b b=%b want 0/0",
                  bus.pe_valid, bus.busy); end
      if (bus.drop_cnt !== 8'd1) begin errors++;
         $display("FAIL drop_cnt got %0d want 1", bus.drop_cnt); end
      if (bus.drop_err !== 1'b1) begin errors++;
         $display("FAIL drop_err got %b want 1", bus.drop_err); end
      if (bus.pe_data !== 8'h11) begin errors++;
         $display("FAIL drop_pe_data got %h want 11", bus.pe_data); end
   endtask

   task automatic test_back_to_back();
      logic [DB-1:0] w [4];
      for (int i = 0; i < 4; i++) w[i] = DB'($urandom);
      @(negedge clk); idle();
      bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd7;
      bus.in_data = w[0];
      tick();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); idle(); bus.pe_ready = 6'h3F;
         if (k < 4) begin
            bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd7;
            bus.in_data = w[k];
         end
         #1; checks += 3;
         if (bus.pe_valid !== 6'h3F) begin errors++;
            $display("FAIL b2b_valid[%0d] got %b want 111111",
                     k, bus.pe_valid); end
         if (bus.pe_data !== w[k-1]) begin errors++;
            $display("FAIL b2b_data[%0d] got %h want %h",
                     k, bus.pe_data, w[k-1]); end
         if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_rdy[%0d] got %b want 1", k, bus.in_ready); end
         tick();
      end
      @(negedge clk); idle();
      #1; checks += 2;
      if (bus.busy !== 1'b0) begin errors++;
         $display("FAIL b2b_busy got %b want 0", bus.busy); end
      if (bus.xfer_cnt !== 8'd6) begin errors++;
         $display("FAIL b2b_xfer got %0d want 6", bus.xfer_cnt); end
   endtask

   task automatic test_scan_block();
      @(negedge clk); idle();
      bus.set_xid = 1; bus.in_valid = 1;
      bus.tag_x = 3'd7; bus.tag_y = 3'd7; bus.in_data = 8'h99;
      #1; checks++;
      if (bus.in_ready !== 1'b0) begin errors++;
         $display("FAIL scan_empty_rdy got %b want 0", bus.in_ready); end
      tick();
      @(negedge clk); idle();
      #1; checks++;
      if (bus.busy !== 1'b0 || bus.pe_valid !== 6'h00) begin errors++;
         $display("FAIL scan_no_accept got b=%b v=%b want 0/0",
                  bus.busy, bus.pe_valid); end
      bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd7;
      bus.in_data = 8'h5C;
      tick();
      @(negedge clk); idle(); bus.set_xid = 1;
      #1; checks++;
      if (bus.pe_valid !== 6'h3F) begin errors++;
         $display("FAIL scan_hold_mask got %b want 111111", bus.pe_valid); end
      tick();
      @(negedge clk); idle(); bus.set_xid = 1; bus.pe_ready = 6'h3F;
      bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd7;
      #1; checks += 3;
      if (bus.pe_valid !== 6'h3F) begin errors++;
         $display("FAIL scan_hold_mask2 got %b want 111111", bus.pe_valid); end
      if (bus.in_ready !== 1'b0) begin errors++;
         $display("FAIL scan_retire_rdy got %b want 0", bus.in_ready); end
      if (bus.pe_data !== 8'h5C) begin errors++;
         $display("FAIL scan_data got %h want 5c", bus.pe_data); end
      tick();
      @(negedge clk); idle();
      #1; checks += 2;
      if (bus.busy !== 1'b0 || bus.pe_valid !== 6'h00) begin errors++;
         $display("FAIL scan_done got b=%b v=%b want 0/0",
                  bus.busy, bus.pe_valid); end
      if (bus.xfer_cnt !== 8'd7) begin errors++;
         $display("FAIL scan_xfer got %0d want 7", bus.xfer_cnt); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); idle();
      bus.in_valid = 1; bus.tag_x = 3'd7; bus.tag_y = 3'd0;
      bus.in_data = 8'h3C;
      tick();
      @(negedge clk); idle(); bus.pe_ready = 6'b000010;
      #1; checks++;
      if (bus.pe_valid !== 6'b000111) begin errors++;
         $display("FAIL ar_mask0 got %b want 000111", bus.pe_valid); end
      tick();
      @(negedge clk); idle();
      #1; checks++;
      if (bus.pe_valid !== 6'b000101) begin errors++;
         $display("FAIL ar_mask1 got %b want 000101", bus.pe_valid); end
      #1 rst = 1;
      #1; checks += 3;
      if (bus.pe_valid !== 6'h00 || bus.busy !== 1'b0) begin errors++;
         $display("FAIL ar_idle got v=%b b=%b want 0/0",
                  bus.pe_valid, bus.busy); end
      if (bus.xfer_cnt !== 8'd0 || bus.drop_cnt !== 8'd0) begin errors++;
         $display("FAIL ar_cnt got %0d/%0d want 0/0",
                  bus.xfer_cnt, bus.drop_cnt); end
      if (bus.drop_err !== 1'b0) begin errors++;
         $display("FAIL ar_drop_err got %b want 0", bus.drop_err); end
      m_reset();
      @(negedge clk); rst = 0; idle();
      bus.in_valid = 1; bus.tag_x = 3'd0; bus.tag_y = 3'd0;
      bus.in_data = 8'h77;
      tick();
      @(negedge clk); idle();
      #1; checks++;
      if (bus.pe_valid !== 6'h3F) begin errors++;
         $display("FAIL ar_zero_ids got %b want 111111", bus.pe_valid); end
      bus.pe_ready = 6'h3F;
      tick();
      @(negedge clk); idle();
      #1; checks++;
      if (bus.busy !== 1'b0 || bus.xfer_cnt !== 8'd1) begin errors++;
         $display("FAIL ar_retire got b=%b x=%0d want 0/1",
                  bus.busy, bus.xfer_cnt); end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < N; i++) scan_x(XB'($urandom_range(0, 3)));
      for (int i = 0; i < NR; i++) scan_y(YB'($urandom_range(0, 3)));
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); idle();
         bus.in_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 4);
         bus.tag_x = (r == 4) ? 3'd7 : XB'(r);
         r = $urandom_range(0, 4);
         bus.tag_y = (r == 4) ? 3'd7 : YB'(r);
         bus.in_data = DB'($urandom);
         bus.pe_ready = N'($urandom);
         bus.set_xid = ($urandom_range(0, 19) == 0);
         bus.xid_scan_in = XB'($urandom_range(0, 3));
         bus.set_yid = ($urandom_range(0, 29) == 0);
         bus.yid_scan_in = YB'($urandom_range(0, 3));
         #1; checks += 6;
         if (bus.pe_valid !== (m_busy ? m_pend : 6'h00)) begin errors++;
            $display("FAIL rnd_valid[%0d] got %b want %b", k,
                     bus.pe_valid, (m_busy ? m_pend : 6'h00)); end
         if (bus.in_ready !== m_rdy()) begin errors++;
            $display("FAIL rnd_rdy[%0d] got %b want %b", k,
                     bus.in_ready, m_rdy()); end
         if (bus.busy !== m_busy) begin errors++;
            $display("FAIL rnd_busy[%0d] got %b want %b", k,
                     bus.busy, m_busy); end
         if (bus.pe_data !== m_data) begin errors++;
            $display("FAIL rnd_data[%0d] got %h want %h", k,
                     bus.pe_data, m_data); end
         if (bus.xfer_cnt !== CB'(m_xfer) ||
             bus.drop_cnt !== CB'(m_drop)) begin errors++;
            $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", k,
                     bus.xfer_cnt, bus.drop_cnt, m_xfer, m_drop); end
         if (bus.drop_err !== m_err) begin errors++;
            $display("FAIL rnd_err[%0d] got %b want %b", k,
                     bus.drop_err, m_err); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_staggered();
      test_drop();
      test_back_to_back();
      test_scan_block();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
